// File: rtl/load_store_ctrl_if.sv
// Signal bundles around the load/store controller: the core request/response
// channel and the data-memory request/response channel.
interface lsc_core_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_data;
    logic        resp_err;

    // The core issues requests; the controller serves them.
    modport master (
        output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
        input  req_ready, resp_valid, resp_data, resp_err
    );
    modport slave (
        input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
        output req_ready, resp_valid, resp_data, resp_err
    );
endinterface

interface lsc_mem_if;
    logic        mem_valid;
    logic        mem_ready;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;

    // The controller drives memory requests; the memory answers.
    modport master (
        output mem_valid, mem_we, mem_addr, mem_wdata, mem_wstrb,
        input  mem_ready, mem_rvalid, mem_rdata
    );
    modport slave (
        input  mem_valid, mem_we, mem_addr, mem_wdata, mem_wstrb,
        output mem_ready, mem_rvalid, mem_rdata
    );
endinterface

// File: rtl/load_store_ctrl.sv
// Sequences one core load/store at a time onto a single-port data memory,
// generating byte strobes on stores and extracting/extending data on loads.
module load_store_ctrl #(
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 5
) (
    input  logic      clk,
    input  logic      rst,
    lsc_core_if.slave core,
    lsc_mem_if.master mem
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        RESP = 2'd3
    } state_e;

    localparam logic [CNT_W-1:0] CNT_LAST = (TIMEOUT == 0) ? '0 : CNT_W'(TIMEOUT - 1);

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              we_q, we_d;
    logic [1:0]        size_q, size_d;
    logic              uns_q, uns_d;
    logic [31:0]       addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [31:0]       resp_data_q, resp_data_d;
    logic              resp_err_q, resp_err_d;

    logic [7:0]        rd_byte [4];
    logic [15:0]       rd_half [2];
    logic [7:0]        ld_byte;
    logic [15:0]       ld_half;
    logic [31:0]       ld_data;
    logic [3:0]        st_strb;
    logic [31:0]       st_wdata;
    logic              in_req;
    logic              st_active;

    function automatic logic is_illegal(input logic [1:0] size, input logic [1:0] off);
        logic bad;
        bad = 1'b0;
        case (size)
            2'd1:    bad = off[0];
            2'd2:    bad = (off != 2'b00);
            2'd3:    bad = 1'b1;
            default: bad = 1'b0;
        endcase
        return bad;
    endfunction

    // Byte and halfword views of the returned word.
    for (genvar gi = 0; gi < 4; gi++) begin : g_byte
        assign rd_byte[gi] = mem.mem_rdata[8*gi +: 8];
    end
    for (genvar gi = 0; gi < 2; gi++) begin : g_half
        assign rd_half[gi] = mem.mem_rdata[16*gi +: 16];
    end

    always_comb begin
        ld_byte = rd_byte[addr_q[1:0]];
        ld_half = rd_half[addr_q[1]];
        case (size_q)
            2'd0:    ld_data = uns_q ? {24'b0, ld_byte} : {{24{ld_byte[7]}}, ld_byte};
            2'd1:    ld_data = uns_q ? {16'b0, ld_half} : {{16{ld_half[15]}}, ld_half};
            default: ld_data = mem.mem_rdata;
        endcase
    end

    // Store lanes: data replicated across the word so any strobe pattern picks it up.
    always_comb begin
        case (size_q)
            2'd0: begin
                st_strb  = 4'b0001 << addr_q[1:0];
                st_wdata = {4{wdata_q[7:0]}};
            end
            2'd1: begin
                st_strb  = 4'b0011 << addr_q[1:0];
                st_wdata = {2{wdata_q[15:0]}};
            end
            default: begin
                st_strb  = 4'b1111;
                st_wdata = wdata_q;
            end
        endcase
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        we_d        = we_q;
        size_d      = size_q;
        uns_d       = uns_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        resp_data_d = resp_data_q;
        resp_err_d  = resp_err_q;

        case (state_q)
            IDLE: begin
                if (core.req_valid) begin
                    we_d    = core.req_we;
                    size_d  = core.req_size;
                    uns_d   = core.req_unsigned;
                    addr_d  = core.req_addr;
                    wdata_d = core.req_wdata;
                    if (is_illegal(core.req_size, core.req_addr[1:0])) begin
                        state_d     = RESP;
                        resp_err_d  = 1'b1;
                        resp_data_d = '0;
                    end else begin
                        state_d = REQ;
                    end
                end
            end
            REQ: begin
                if (mem.mem_ready) begin
                    if (we_q) begin
                        state_d     = RESP;
                        resp_err_d  = 1'b0;
                        resp_data_d = '0;
                    end else begin
                        state_d = WAIT;
                        cnt_d   = '0;
                    end
                end
            end
            WAIT: begin
                // Checking rvalid first lets a response on the last allowed cycle win.
                if (mem.mem_rvalid) begin
                    state_d     = RESP;
                    resp_err_d  = 1'b0;
                    resp_data_d = ld_data;
                end else if ((TIMEOUT != 0) && (cnt_q == CNT_LAST)) begin
                    state_d     = RESP;
                    resp_err_d  = 1'b1;
                    resp_data_d = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            we_q        <= 1'b0;
            size_q      <= '0;
            uns_q       <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            resp_data_q <= '0;
            resp_err_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            we_q        <= we_d;
            size_q      <= size_d;
            uns_q       <= uns_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            resp_data_q <= resp_data_d;
            resp_err_q  <= resp_err_d;
        end
    end

    assign in_req    = (state_q == REQ);
    assign st_active = in_req & we_q;

    assign core.req_ready  = (state_q == IDLE);
    assign core.resp_valid = (state_q == RESP);
    assign core.resp_data  = resp_data_q;
    assign core.resp_err   = resp_err_q;

    assign mem.mem_valid = in_req;
    assign mem.mem_we    = st_active;
    assign mem.mem_addr  = in_req ? {addr_q[31:2], 2'b00} : 32'h0;
    assign mem.mem_wstrb = st_active ? st_strb : 4'b0000;
    assign mem.mem_wdata = st_active ? st_wdata : 32'h0;

endmodule

// File: tb/tb_load_store_ctrl.sv
// Directed bench for load_store_ctrl: loads, stores, illegal requests,
// timeout and mid-transaction reset, with hand-computed expectations.
module tb_load_store_ctrl;
    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    lsc_core_if core_if();
    lsc_mem_if  mem_if();

    load_store_ctrl #(.TIMEOUT(16), .CNT_W(5)) dut (
        .clk  (clk),
        .rst  (rst),
        .core (core_if.slave),
        .mem  (mem_if.master)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge; outputs depend only on state.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic we, input logic [1:0] size, input logic uns,
                         input logic [31:0] addr, input logic [31:0] wdata);
        core_if.req_valid    = 1'b1;
        core_if.req_we       = we;
        core_if.req_size     = size;
        core_if.req_unsigned = uns;
        core_if.req_addr     = addr;
        core_if.req_wdata    = wdata;
    endtask

    // Legal load: mem_ready at cycle 1, rvalid at cycle 2, response at cycle 3.
    task automatic run_load(input logic [1:0] size, input logic uns, input logic [31:0] addr,
                            input logic [31:0] rdata, input logic [31:0] exp);
        issue(1'b0, size, uns, addr, 32'h0);
        mem_if.mem_ready = 1'b1;
        chk("ld_req_ready_c0", core_if.req_ready, 1'b1);
        step();
        core_if.req_valid = 1'b0;
        chk("ld_mem_valid_c1", mem_if.mem_valid, 1'b1);
        chk("ld_mem_addr_c1", mem_if.mem_addr, addr & 32'hFFFF_FFFC);
        chk("ld_mem_wstrb_c1", mem_if.mem_wstrb, 4'b0000);
        chk("ld_mem_we_c1", mem_if.mem_we, 1'b0);
        chk("ld_req_ready_c1", core_if.req_ready, 1'b0);
        step();
        mem_if.mem_ready  = 1'b0;
        mem_if.mem_rvalid = 1'b1;
        mem_if.mem_rdata  = rdata;
        chk("ld_mem_valid_c2", mem_if.mem_valid, 1'b0);
        chk("ld_resp_valid_c2", core_if.resp_valid, 1'b0);
        step();
        mem_if.mem_rvalid = 1'b0;
        chk("ld_resp_valid_c3", core_if.resp_valid, 1'b1);
        chk("ld_resp_data_c3", core_if.resp_data, exp);
        chk("ld_resp_err_c3", core_if.resp_err, 1'b0);
        chk("ld_req_ready_c3", core_if.req_ready, 1'b0);
        step();
        chk("ld_resp_valid_c4", core_if.resp_valid, 1'b0);
        chk("ld_resp_hold_c4", core_if.resp_data, exp);
        chk("ld_req_ready_c4", core_if.req_ready, 1'b1);
        $display("txn load  size=%0d uns=%0b addr=%h rdata=%h -> data=%h err=%0b",
                 size, uns, addr, rdata, core_if.resp_data, core_if.resp_err);
    endtask

    // Store with `stall` cycles of mem_ready low before the handshake.
    task automatic run_store(input logic [1:0] size, input logic [31:0] addr,
                             input logic [31:0] wdata, input int stall,
                             input logic [3:0] exp_strb, input logic [31:0] exp_wdata);
        issue(1'b1, size, 1'b0, addr, wdata);
        step();
        core_if.req_valid = 1'b0;
        for (int i = 0; i <= stall; i++) begin
            mem_if.mem_ready = (i == stall);
            chk("st_mem_valid", mem_if.mem_valid, 1'b1);
            chk("st_mem_we", mem_if.mem_we, 1'b1);
            chk("st_mem_addr", mem_if.mem_addr, addr & 32'hFFFF_FFFC);
            chk("st_mem_wstrb", mem_if.mem_wstrb, exp_strb);
            chk("st_mem_wdata", mem_if.mem_wdata, exp_wdata);
            chk("st_resp_valid_req", core_if.resp_valid, 1'b0);
            step();
        end
        mem_if.mem_ready = 1'b0;
        chk("st_resp_valid", core_if.resp_valid, 1'b1);
        chk("st_resp_data", core_if.resp_data, 32'h0);
        chk("st_resp_err", core_if.resp_err, 1'b0);
        chk("st_mem_valid_resp", mem_if.mem_valid, 1'b0);
        step();
        chk("st_resp_valid_after", core_if.resp_valid, 1'b0);
        $display("txn store size=%0d addr=%h wdata=%h stall=%0d -> strb=%b lanes=%h",
                 size, addr, wdata, stall, exp_strb, exp_wdata);
    endtask

    // Illegal request: error response at cycle 1, memory never requested.
    task automatic run_illegal(input logic we, input logic [1:0] size, input logic [31:0] addr);
        issue(we, size, 1'b0, addr, 32'h1234_5678);
        chk("il_req_ready_c0", core_if.req_ready, 1'b1);
        step();
        core_if.req_valid = 1'b0;
        chk("il_mem_valid_c1", mem_if.mem_valid, 1'b0);
        chk("il_resp_valid_c1", core_if.resp_valid, 1'b1);
        chk("il_resp_err_c1", core_if.resp_err, 1'b1);
        chk("il_resp_data_c1", core_if.resp_data, 32'h0);
        step();
        chk("il_mem_valid_c2", mem_if.mem_valid, 1'b0);
        chk("il_resp_valid_c2", core_if.resp_valid, 1'b0);
        chk("il_resp_err_hold", core_if.resp_err, 1'b1);
        $display("txn illegal we=%0b size=%0d addr=%h -> err response", we, size, addr);
    endtask

    initial begin
        core_if.req_valid    = 1'b0;
        core_if.req_we       = 1'b0;
        core_if.req_size     = 2'd0;
        core_if.req_unsigned = 1'b0;
        core_if.req_addr     = 32'h0;
        core_if.req_wdata    = 32'h0;
        mem_if.mem_ready     = 1'b0;
        mem_if.mem_rvalid    = 1'b0;
        mem_if.mem_rdata     = 32'h0;
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;

        chk("rst_req_ready", core_if.req_ready, 1'b1);
        chk("rst_mem_valid", mem_if.mem_valid, 1'b0);
        chk("rst_mem_addr", mem_if.mem_addr, 32'h0);
        chk("rst_mem_wstrb", mem_if.mem_wstrb, 4'b0000);
        chk("rst_resp_valid", core_if.resp_valid, 1'b0);
        chk("rst_resp_data", core_if.resp_data, 32'h0);
        chk("rst_resp_err", core_if.resp_err, 1'b0);
        $display("txn reset");

        run_load(2'd0, 1'b0, 32'h0000_1003, 32'h80FF_1234, 32'hFFFF_FF80);
        run_load(2'd1, 1'b1, 32'h0000_2002, 32'hBEEF_0001, 32'h0000_BEEF);
        run_load(2'd1, 1'b0, 32'h0000_2002, 32'hBEEF_0001, 32'hFFFF_BEEF);
        run_load(2'd0, 1'b1, 32'h0000_1002, 32'h80FF_1234, 32'h0000_00FF);
        run_load(2'd1, 1'b0, 32'h0000_2000, 32'hBEEF_8001, 32'hFFFF_8001);
        run_load(2'd2, 1'b0, 32'h0000_2004, 32'hCAFE_F00D, 32'hCAFE_F00D);

        run_illegal(1'b0, 2'd2, 32'h0000_4001);
        run_illegal(1'b0, 2'd3, 32'h0000_5000);
        run_illegal(1'b0, 2'd1, 32'h0000_4003);
        run_illegal(1'b1, 2'd2, 32'h0000_4002);

        run_store(2'd1, 32'h0000_3002, 32'h0000_A5C3, 3, 4'b1100, 32'hA5C3_A5C3);
        run_store(2'd0, 32'h0000_6001, 32'h1234_5678, 0, 4'b0010, 32'h7878_7878);
        run_store(2'd2, 32'h0000_6000, 32'hDEAD_BEEF, 1, 4'b1111, 32'hDEAD_BEEF);
        run_store(2'd0, 32'h0000_6003, 32'h0000_00AB, 0, 4'b1000, 32'hABAB_ABAB);

        // Timeout: handshake at cycle 1, WAIT cycles 2..17, error response at 18.
        issue(1'b0, 2'd2, 1'b0, 32'h0000_7000, 32'h0);
        mem_if.mem_ready = 1'b1;
        step();
        core_if.req_valid = 1'b0;
        step();
        mem_if.mem_ready = 1'b0;
        for (int i = 0; i < 16; i++) begin
            chk("to_wait_resp_valid", core_if.resp_valid, 1'b0);
            chk("to_wait_mem_valid", mem_if.mem_valid, 1'b0);
            step();
        end
        chk("to_resp_valid", core_if.resp_valid, 1'b1);
        chk("to_resp_err", core_if.resp_err, 1'b1);
        chk("to_resp_data", core_if.resp_data, 32'h0);
        step();
        step();
        mem_if.mem_rvalid = 1'b1;
        mem_if.mem_rdata  = 32'h5555_AAAA;
        step();
        mem_if.mem_rvalid = 1'b0;
        chk("to_late_resp_valid", core_if.resp_valid, 1'b0);
        chk("to_late_mem_valid", mem_if.mem_valid, 1'b0);
        chk("to_late_req_ready", core_if.req_ready, 1'b1);
        chk("to_late_err_hold", core_if.resp_err, 1'b1);
        step();
        chk("to_late_resp_valid2", core_if.resp_valid, 1'b0);
        $display("txn load  addr=00007000 -> timeout err, late rvalid dropped");

        run_load(2'd2, 1'b0, 32'h0000_7000, 32'h1357_9BDF, 32'h1357_9BDF);

        // rvalid on the final allowed WAIT cycle (counter at TIMEOUT-1) wins.
        issue(1'b0, 2'd2, 1'b0, 32'h0000_8000, 32'h0);
        mem_if.mem_ready = 1'b1;
        step();
        core_if.req_valid = 1'b0;
        step();
        mem_if.mem_ready = 1'b0;
        for (int i = 0; i < 15; i++) begin
            chk("race_wait_resp_valid", core_if.resp_valid, 1'b0);
            step();
        end
        mem_if.mem_rvalid = 1'b1;
        mem_if.mem_rdata  = 32'h0BAD_F00D;
        step();
        mem_if.mem_rvalid = 1'b0;
        chk("race_resp_valid", core_if.resp_valid, 1'b1);
        chk("race_resp_err", core_if.resp_err, 1'b0);
        chk("race_resp_data", core_if.resp_data, 32'h0BAD_F00D);
        step();
        $display("txn load  addr=00008000 rvalid on last cycle -> data=0badf00d");

        // Reset while in WAIT aborts silently; a later rvalid is ignored.
        issue(1'b0, 2'd2, 1'b0, 32'h0000_9000, 32'h0);
        mem_if.mem_ready = 1'b1;
        step();
        core_if.req_valid = 1'b0;
        step();
        mem_if.mem_ready = 1'b0;
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("wrst_req_ready", core_if.req_ready, 1'b1);
        chk("wrst_mem_valid", mem_if.mem_valid, 1'b0);
        chk("wrst_mem_addr", mem_if.mem_addr, 32'h0);
        chk("wrst_mem_we", mem_if.mem_we, 1'b0);
        chk("wrst_resp_valid", core_if.resp_valid, 1'b0);
        chk("wrst_resp_data", core_if.resp_data, 32'h0);
        chk("wrst_resp_err", core_if.resp_err, 1'b0);
        mem_if.mem_rvalid = 1'b1;
        mem_if.mem_rdata  = 32'hFFFF_FFFF;
        step();
        mem_if.mem_rvalid = 1'b0;
        chk("wrst_late_resp_valid", core_if.resp_valid, 1'b0);
        step();
        chk("wrst_late_resp_valid2", core_if.resp_valid, 1'b0);
        chk("wrst_late_resp_data", core_if.resp_data, 32'h0);
        chk("wrst_late_req_ready", core_if.req_ready, 1'b1);
        $display("txn load  addr=00009000 aborted by reset in WAIT");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/load_store_ctrl.md
Name: load_store_ctrl

Overview:
Sequences every core load/store onto a single-port data memory with valid/ready request and rvalid response handshakes. Checks size/alignment and generates byte-lane strobes and replicated store data. Extracts the addressed byte, halfword or word from the returned word and sign- or zero-extends it to 32 bits. Sits between the execute stage and data memory, and feeds the writeback mux.

Parameters:
TIMEOUT, 16, max cycles in WAIT for mem_rvalid before an error response; 0 disables the timeout.
CNT_W, 5, width of the timeout counter; must hold TIMEOUT.

Ports:
clk  in  1  system clock, all state updates on rising edge
rst  in  1  synchronous active-high reset
req_valid  in  1  core request valid
req_ready  out  1  controller can accept a request
req_we  in  1  1=store, 0=load
req_size  in  2  0=byte, 1=half, 2=word, 3=reserved
req_unsigned  in  1  1=zero-extend load, 0=sign-extend
req_addr  in  32  byte address
req_wdata  in  32  store data, right-aligned
mem_valid  out  1  memory request valid
mem_ready  in  1  memory accepts request
mem_we  out  1  write enable
mem_addr  out  32  word address: {addr[31:2],2'b00}
mem_wdata  out  32  lane-replicated store data
mem_wstrb  out  4  byte strobes; 0000 for loads
mem_rvalid  in  1  read data valid
mem_rdata  in  32  read word
resp_valid  out  1  one-cycle completion pulse
resp_data  out  32  extended load data; 0 for stores and errors
resp_err  out  1  valid with resp_valid: misaligned, reserved size or timeout

Behaviour:
- Interface: one clock, clk; reset is synchronous and active-high, rst.
- Reset: state=IDLE, counter=0; req_ready=1, all other outputs 0, captured request regs 0. Reset mid-transaction aborts with no resp_valid. mem_rvalid arriving after reset is ignored.
- States: IDLE, REQ, WAIT, RESP.
- IDLE: req_ready=1. On req_valid:
  - Capture we, size, unsigned, addr, wdata.
  - If the request is illegal, go to RESP with err=1.
  - Illegal means any of: size=3; size=1 with addr[0]=1; size=2 with addr[1:0]!=0.
  - Otherwise go to REQ.
- REQ:
  - mem_valid=1; mem_addr, mem_we, mem_wdata and mem_wstrb held stable until mem_ready.
  - On mem_ready: stores go to RESP with err=0; loads go to WAIT with counter cleared.
  - mem_rvalid in REQ is ignored.
- WAIT:
  - mem_valid=0.
  - On mem_rvalid: register the extracted data into resp_data and go to RESP.
  - Otherwise counter increments each cycle.
  - If TIMEOUT!=0 and counter reaches TIMEOUT-1 without rvalid, go to RESP with err=1 and data=0.
  - If rvalid coincides with the timeout cycle, rvalid wins (no error).
- RESP: resp_valid=1 for exactly one cycle, req_ready=0; next state is IDLE. Outside RESP, resp_valid=0, and resp_data/resp_err hold their last values.
- Store lanes, with off=addr[1:0]:
  - byte: wstrb=0001<<off, wdata={4{wdata[7:0]}}.
  - half: wstrb=0011<<off, wdata={2{wdata[15:0]}}.
  - word: wstrb=1111, wdata=wdata.
- Load extract:
  - byte: b=rdata[8*off+7:8*off]; result = unsigned ? {24'b0,b} : {{24{b[7]}},b}.
  - half: h=rdata[16*addr[1]+15:16*addr[1]]; extended the same way to 32 bits.
  - word: rdata unchanged.
- Latency, legal load: request accepted cycle 0, mem_valid cycle 1. With mem_ready at cycle 1 and rvalid at cycle 2, resp_valid is at cycle 3.
- Latency, other cases:
  - Store: resp_valid one cycle after the mem_ready handshake.
  - Illegal request: resp_valid at cycle 1, and mem_valid never asserts.
- Throughput: at most one outstanding transaction. The next request is accepted in the IDLE cycle after RESP.
- Late rvalid: mem_rvalid arriving in IDLE or RESP (e.g. after a timeout) is dropped.

Test Plan:
- Load byte signed, addr=0x1003, rdata=0x80FF_1234 at first WAIT cycle, mem_ready immediate -> mem_addr=0x1000, wstrb=0000; resp_valid at cycle 3, resp_data=0xFFFF_FF80, err=0.
- Load half unsigned, addr=0x2002, rdata=0xBEEF_0001 -> resp_data=0x0000_BEEF; repeat with signed -> 0xFFFF_BEEF.
- Store half, addr=0x3002, wdata=0x0000_A5C3, mem_ready held low 3 cycles -> mem_valid/addr/wdata stable for 4 cycles; mem_addr=0x3000, wstrb=1100, mem_wdata=0xA5C3_A5C3; resp_valid one cycle after acceptance, resp_data=0.
- Misaligned word, addr=0x4001; separately size=3 -> mem_valid never asserts; resp_valid at cycle 1 with err=1.
- Timeout with TIMEOUT=16 and no rvalid -> err response exactly 16 WAIT cycles after mem_ready handshake. An rvalid issued 2 cycles later is ignored, and a following load completes normally.
- rst asserted in WAIT -> next cycle req_ready=1, all other outputs 0; no resp_valid; a subsequent rvalid is ignored.
